// File: rtl/shift_pkg.sv
// Shared constants, op encoding and reference shift function for the shift arbiter.
// Latency: n/a (package, no logic).
// Backpressure: n/a.
package shift_pkg;

    localparam int DATA_W = 16;
    localparam int AMT_W  = 4;

    typedef enum logic [1:0] {
        OP_SHL = 2'b00,
        OP_SHR = 2'b01,
        OP_ROL = 2'b10,
        OP_ROR = 2'b11
    } shift_op_e;

    // Behavioural reference: rotates are taken from a doubled word so no wrap logic is needed.
    function automatic logic [DATA_W-1:0] shift_fn(
        input logic [1:0]        op,
        input logic [AMT_W-1:0]  amt,
        input logic [DATA_W-1:0] data
    );
        logic [2*DATA_W-1:0] dbl;
        dbl = {data, data};
        case (shift_op_e'(op))
            OP_SHL: shift_fn = data << amt;
            OP_SHR: shift_fn = data >> amt;
            OP_ROL: begin
                dbl      = dbl << amt;
                shift_fn = dbl[2*DATA_W-1:DATA_W];
            end
            default: begin
                dbl      = dbl >> amt;
                shift_fn = dbl[DATA_W-1:0];
            end
        endcase
    endfunction

endpackage

// File: rtl/shift_core.sv
// Combinational 16-bit shift/rotate barrel: four stages of 1/2/4/8 selected by amount bits.
// Latency: 0 cycles, no state.
// Backpressure: none, pure function of its inputs.
module shift_core
    import shift_pkg::*;
(
    input  logic [1:0]        op,
    input  logic [AMT_W-1:0]  amt,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] stage [AMT_W+1];

    assign stage[0] = data;

    for (genvar s = 0; s < AMT_W; s++) begin : g_stage
        localparam int K = 1 << s;

        logic [DATA_W-1:0] in_w;
        logic [DATA_W-1:0] sh;

        assign in_w = stage[s];

        always_comb begin
            sh = in_w;
            case (shift_op_e'(op))
                OP_SHL: sh = in_w << K;
                OP_SHR: sh = in_w >> K;
                OP_ROL: sh = {in_w[DATA_W-K-1:0], in_w[DATA_W-1:DATA_W-K]};
                OP_ROR: sh = {in_w[K-1:0], in_w[DATA_W-1:K]};
            endcase
        end

        assign stage[s+1] = amt[s] ? sh : in_w;
    end

    assign result = stage[AMT_W];

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift_core among NREQ requesters, one-entry tagged result register.
// Latency: 1 cycle from accept to resp_valid; throughput 1 result/cycle when resp_ready stays high.
// Backpressure: while resp_valid && !resp_ready the result holds and req_ready is all zero.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [2*NREQ-1:0]       req_op,
    input  logic [AMT_W*NREQ-1:0]   req_amt,
    input  logic [DATA_W*NREQ-1:0]  req_data,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_W-1:0]       resp_data,
    output logic [IDW-1:0]          resp_id
);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("shift_arbiter: NREQ must be in 2..8");
    end

    logic [IDW-1:0]    rr_ptr;
    logic              slot_free;
    logic              grant_vld;
    logic [IDW-1:0]    grant_idx;
    logic [1:0]        sel_op;
    logic [AMT_W-1:0]  sel_amt;
    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] core_result;

    assign slot_free = !resp_valid || resp_ready;

    // Search upward from rr_ptr with wrap; only handshake signals feed this path.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        if (!reset && slot_free) begin
            for (int off = 0; off < NREQ; off++) begin
                idx = (int'(rr_ptr) + off) % NREQ;
                if (!grant_vld && req_valid[idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = IDW'(idx);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign sel_op   = req_op[int'(grant_idx)*2 +: 2];
    assign sel_amt  = req_amt[int'(grant_idx)*AMT_W +: AMT_W];
    assign sel_data = req_data[int'(grant_idx)*DATA_W +: DATA_W];

    shift_core u_core (
        .op     (sel_op),
        .amt    (sel_amt),
        .data   (sel_data),
        .result (core_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
            rr_ptr     <= '0;
        end else if (grant_vld) begin
            resp_valid <= 1'b1;
            resp_data  <= core_result;
            resp_id    <= grant_idx;
            rr_ptr     <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
        end else if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    // Barrel stages must agree with the behavioural reference on every accepted request.
    always_ff @(posedge clk) begin
        if (!reset && grant_vld) begin
            assert (core_result == shift_fn(sel_op, sel_amt, sel_data))
                else $error("shift_core disagrees with shift_fn");
        end
    end

    assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));

    assert property (@(posedge clk) disable iff (reset)
        resp_valid && !resp_ready |=> resp_valid && $stable(resp_data) && $stable(resp_id));

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: vector table, directed corner sequences, random scoreboard.
module tb_shift_arbiter;
    import shift_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = $clog2(NREQ);

    logic                   clk;
    logic                   reset;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [2*NREQ-1:0]      req_op;
    logic [AMT_W*NREQ-1:0]  req_amt;
    logic [DATA_W*NREQ-1:0] req_data;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [DATA_W-1:0]      resp_data;
    logic [IDW-1:0]         resp_id;

    logic [1:0]        tv_op   [NREQ];
    logic [AMT_W-1:0]  tv_amt  [NREQ];
    logic [DATA_W-1:0] tv_data [NREQ];
    logic [NREQ-1:0]   tv_valid;
    logic              tv_rdy;
    logic              tv_rst;

    assign req_valid  = tv_valid;
    assign resp_ready = tv_rdy;
    assign reset      = tv_rst;

    for (genvar i = 0; i < NREQ; i++) begin : g_pack
        assign req_op[2*i +: 2]             = tv_op[i];
        assign req_amt[AMT_W*i +: AMT_W]    = tv_amt[i];
        assign req_data[DATA_W*i +: DATA_W] = tv_data[i];
    end

    shift_arbiter #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_amt    (req_amt),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  amt;
        logic [15:0] data;
        int          id;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        int          id;
        logic [15:0] data;
    } exp_t;

    int n_chk;
    int n_pass;

    // Reference model state
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [IDW-1:0]    m_id;
    int                m_rr;
    logic [NREQ-1:0]   m_grant;
    exp_t              sb_q [$];
    int                push_cnt [NREQ];
    int                pop_cnt  [NREQ];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Called just after a negedge with tv_* driven; returns at the next negedge.
    task automatic step();
        logic [NREQ-1:0] exp_rdy;
        logic            free;
        int              g;
        exp_t            e;
        #1;
        exp_rdy = '0;
        g       = -1;
        free    = !m_valid || tv_rdy;
        if (!tv_rst && free) begin
            for (int off = 0; off < NREQ; off++) begin
                int idx;
                idx = (m_rr + off) % NREQ;
                if (g < 0 && tv_valid[idx]) g = idx;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;

        chk("req_ready", req_ready, exp_rdy);
        chk("resp_valid", resp_valid, m_valid);
        chk("resp_data", resp_data, m_data);
        chk("resp_id", resp_id, m_id);

        if (tv_rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_id    = '0;
            m_rr    = 0;
            sb_q.delete();
            for (int i = 0; i < NREQ; i++) begin
                push_cnt[i] = 0;
                pop_cnt[i]  = 0;
            end
        end else begin
            if (m_valid && tv_rdy) begin
                if (sb_q.size() == 0) begin
                    chk("sb_nonempty", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_data", resp_data, e.data);
                    chk("sb_id", resp_id, e.id);
                    pop_cnt[e.id]++;
                end
            end
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = shift_fn(tv_op[g], tv_amt[g], tv_data[g]);
                m_id    = IDW'(g);
                m_rr    = (g + 1) % NREQ;
                e.id    = g;
                e.data  = m_data;
                sb_q.push_back(e);
                push_cnt[g]++;
            end else if (m_valid && tv_rdy) begin
                m_valid = 1'b0;
            end
        end
        m_grant = exp_rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [3:0] amt, input logic [15:0] d);
        tv_op[i]   = op;
        tv_amt[i]  = amt;
        tv_data[i] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [8];
        vecs[0] = '{2'b00, 4'd1, 16'h75AB, 0, 16'hEB56};
        vecs[1] = '{2'b01, 4'd4, 16'h75AB, 1, 16'h075A};
        vecs[2] = '{2'b10, 4'd8, 16'h75AB, 2, 16'hAB75};
        vecs[3] = '{2'b11, 4'd1, 16'h75AB, 3, 16'hBAD5};
        vecs[4] = '{2'b00, 4'd0, 16'h75AB, 0, 16'h75AB};
        vecs[5] = '{2'b01, 4'd0, 16'h75AB, 1, 16'h75AB};
        vecs[6] = '{2'b10, 4'd0, 16'h75AB, 2, 16'h75AB};
        vecs[7] = '{2'b11, 4'd0, 16'h75AB, 3, 16'h75AB};

        n_chk   = 0;
        n_pass  = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = '0;
        m_rr    = 0;
        m_grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 2'b00, 4'd0, 16'h0000);
            push_cnt[i] = 0;
            pop_cnt[i]  = 0;
        end

        // Reset state, with every requester valid to show req_ready is masked
        tv_rst   = 1'b1;
        tv_valid = '1;
        tv_rdy   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_req_ready", req_ready, '0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_data", resp_data, 16'h0000);
        chk("rst_resp_id", resp_id, '0);
        tv_rst   = 1'b0;
        tv_valid = '0;

        // Single requests from the table
        for (int k = 0; k < 8; k++) begin
            tv_valid = '0;
            tv_valid[vecs[k].id] = 1'b1;
            set_req(vecs[k].id, vecs[k].op, vecs[k].amt, vecs[k].data);
            tv_rdy = 1'b1;
            step();
            chk("vec_valid", resp_valid, 1'b1);
            chk("vec_data", resp_data, vecs[k].exp);
            chk("vec_id", resp_id, vecs[k].id);
        end

        // Fairness: all requesters valid, consumer always ready
        tv_valid = '1;
        for (int i = 0; i < NREQ; i++) set_req(i, 2'(i), 4'(i + 3), 16'h1234 + 16'(i));
        for (int k = 0; k < 8; k++) begin
            step();
            chk("fair_id", resp_id, k % NREQ);
            chk("fair_valid", resp_valid, 1'b1);
        end
        tv_valid = '0;
        step();

        // Backpressure with 16'hEB56 pending and requester 2 waiting
        tv_valid = 4'b0001;
        set_req(0, 2'b00, 4'd1, 16'h75AB);
        step();
        chk("bp_pending", resp_data, 16'hEB56);
        tv_valid = 4'b0100;
        set_req(2, 2'b10, 4'd8, 16'h75AB);
        tv_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ready", req_ready, '0);
            step();
            chk("bp_data", resp_data, 16'hEB56);
            chk("bp_valid", resp_valid, 1'b1);
        end
        tv_rdy = 1'b1;
        #1;
        chk("bp_release_ready", req_ready, 4'b0100);
        step();
        chk("bp_grant_id", resp_id, 2);
        chk("bp_grant_data", resp_data, 16'hAB75);

        // Wrap: pointer now at 3, only requester 0 valid
        tv_valid = 4'b0001;
        step();
        chk("wrap_id0", resp_id, 0);
        tv_valid = 4'b0011;
        step();
        chk("wrap_id1", resp_id, 1);
        tv_valid = 4'b1000;
        step();
        chk("wrap_id3", resp_id, 3);
        tv_valid = 4'b0001;
        step();
        chk("wrap_after3", resp_id, 0);
        tv_valid = 4'b0011;
        step();
        chk("wrap_next", resp_id, 1);

        // Reset mid-stream with a held result and all requesters valid
        tv_valid = '1;
        step();
        chk("mid_pre_valid", resp_valid, 1'b1);
        tv_rst = 1'b1;
        step();
        chk("mid_rst_valid", resp_valid, 1'b0);
        chk("mid_rst_data", resp_data, 16'h0000);
        chk("mid_rst_ready", req_ready, '0);
        tv_rst = 1'b0;
        step();
        chk("mid_first_grant", resp_id, 0);

        // Random traffic; a waiting requester keeps its request unless it drops out
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (tv_valid[i] && !m_grant[i]) begin
                    if ($urandom_range(0, 7) == 0) tv_valid[i] = 1'b0;
                end else begin
                    tv_valid[i] = 1'($urandom_range(0, 1));
                    set_req(i, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 16'($urandom));
                end
            end
            tv_rdy = ($urandom_range(0, 9) < 7);
            step();
        end

        tv_valid = '0;
        tv_rdy   = 1'b1;
        repeat (2) step();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        for (int i = 0; i < NREQ; i++) begin
            chk("sb_count", pop_cnt[i], push_cnt[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
